// File: rtl/ltc2145_rx.sv
// ltc2145_rx: two-channel LTC2145 capture with offset-binary to two's complement conversion, lock/settle gating and sticky over-range flags
module ltc2145_rx #(
  parameter int DATA_WIDTH    = 14,
  parameter int SETTLE_CYCLES = 1024,
  parameter int INVERT_A      = 1,
  parameter int INVERT_B      = 1
) (
  input  logic                  adc_clk_i,
  input  logic                  adc_rst_ni,
  input  logic                  adc_locked_i,
  input  logic [DATA_WIDTH-1:0] adc_dat_a_i,
  input  logic [DATA_WIDTH-1:0] adc_dat_b_i,
  input  logic                  ovr_clr_i,
  output logic [DATA_WIDTH-1:0] dat_a_o,
  output logic                  dat_a_en_o,
  output logic                  dat_a_rst_o,
  output logic [DATA_WIDTH-1:0] dat_b_o,
  output logic                  dat_b_en_o,
  output logic                  dat_b_rst_o,
  output logic                  ovr_a_o,
  output logic                  ovr_b_o,
  output logic [1:0]            state_o
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] ONES = '1;
  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, RUN = 2'd2} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic lock_m, lock_s, en_q;
  logic [DATA_WIDTH-1:0] raw_a, raw_b, cv_a, cv_b;
  function automatic logic [DATA_WIDTH-1:0] conv(input logic [DATA_WIDTH-1:0] r, input logic inv);
    logic [DATA_WIDTH-1:0] t;
    t = {~r[DATA_WIDTH-1], r[DATA_WIDTH-2:0]};
    conv = !inv ? t : (t == {1'b1, {(DATA_WIDTH-1){1'b0}}}) ? {1'b0, {(DATA_WIDTH-1){1'b1}}} : -t;
  endfunction
  always_ff @(posedge adc_clk_i or negedge adc_rst_ni)
    if (!adc_rst_ni) {lock_s, lock_m} <= 2'b00;
    else {lock_s, lock_m} <= {lock_m, adc_locked_i};
  always_ff @(posedge adc_clk_i or negedge adc_rst_ni)
    if (!adc_rst_ni) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  always_comb begin
    state_d = !lock_s ? IDLE :
              state == IDLE ? SETTLE :
              (state == SETTLE && cnt == LAST) ? RUN : state;
    cnt_d = (lock_s && state == SETTLE) ? cnt + CW'(1) : '0;
  end
  always_ff @(posedge adc_clk_i or negedge adc_rst_ni)
    if (!adc_rst_ni) begin
      raw_a   <= '0;
      raw_b   <= '0;
      cv_a    <= '0;
      cv_b    <= '0;
      dat_a_o <= '0;
      dat_b_o <= '0;
      en_q    <= 1'b0;
      ovr_a_o <= 1'b0;
      ovr_b_o <= 1'b0;
    end else begin
      raw_a   <= adc_dat_a_i;
      raw_b   <= adc_dat_b_i;
      cv_a    <= conv(raw_a, INVERT_A != 0);
      cv_b    <= conv(raw_b, INVERT_B != 0);
      dat_a_o <= cv_a;
      dat_b_o <= cv_b;
      en_q    <= state == RUN;
      ovr_a_o <= (state == RUN && (raw_a == '0 || raw_a == ONES)) ? 1'b1 : ovr_clr_i ? 1'b0 : ovr_a_o;
      ovr_b_o <= (state == RUN && (raw_b == '0 || raw_b == ONES)) ? 1'b1 : ovr_clr_i ? 1'b0 : ovr_b_o;
    end
  assign dat_a_en_o  = en_q;
  assign dat_b_en_o  = en_q;
  assign dat_a_rst_o = ~en_q;
  assign dat_b_rst_o = ~en_q;
  assign state_o     = state;
endmodule

// File: tb/tb_ltc2145_rx.sv
// tb_ltc2145_rx: scoreboard bench for ltc2145_rx with directed vectors and hand-computed expectations
module tb_ltc2145_rx;
  logic        clk = 1'b0, rst_n = 1'b0, locked = 1'b0, clr = 1'b0;
  logic [13:0] din_a = 14'h2000, din_b = 14'h2000;
  logic [13:0] dat_a, dat_b;
  logic        en_a, en_b, rs_a, rs_b, ovr_a, ovr_b;
  logic [1:0]  st;
  int          total = 0, bad = 0, cyc = 0;

  typedef struct {logic [13:0] a; logic [13:0] b; int due;} exp_t;
  exp_t q[$];

  ltc2145_rx #(.DATA_WIDTH(14), .SETTLE_CYCLES(16), .INVERT_A(0), .INVERT_B(1)) dut (
    .adc_clk_i(clk), .adc_rst_ni(rst_n), .adc_locked_i(locked),
    .adc_dat_a_i(din_a), .adc_dat_b_i(din_b), .ovr_clr_i(clr),
    .dat_a_o(dat_a), .dat_a_en_o(en_a), .dat_a_rst_o(rs_a),
    .dat_b_o(dat_b), .dat_b_en_o(en_b), .dat_b_rst_o(rs_b),
    .ovr_a_o(ovr_a), .ovr_b_o(ovr_b), .state_o(st));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() != 0 && q[0].due < cyc) begin
      total++;
      bad++;
      $display("FAIL missed sample due %0d at cycle %0d", q[0].due, cyc);
      void'(q.pop_front());
    end
    if (q.size() != 0 && q[0].due == cyc) begin
      chk("data_a", 32'(dat_a), 32'(q[0].a));
      chk("data_b", 32'(dat_b), 32'(q[0].b));
      chk("data_en", 32'(en_a & en_b), 32'd1);
      void'(q.pop_front());
    end
  end

  task automatic drv(input logic [13:0] a, input logic [13:0] b, input logic [13:0] ea, input logic [13:0] eb);
    @(negedge clk);
    din_a = a;
    din_b = b;
    q.push_back('{ea, eb, cyc + 3});
  endtask

  task automatic check_sb(input int ste, input logic ene);
    chk("state", 32'(st), 32'(ste));
    chk("en_a", 32'(en_a), 32'(ene));
    chk("en_b", 32'(en_b), 32'(ene));
    chk("rst_a", 32'(rs_a), 32'(!ene));
    chk("rst_b", 32'(rs_b), 32'(!ene));
  endtask

  // Releases reset with lock already high; L is the first edge that samples lock.
  task automatic startup();
    int l;
    @(negedge clk);
    rst_n  = 1'b1;
    locked = 1'b1;
    l = cyc + 1;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      check_sb((cyc - l) < 2 ? 0 : (cyc - l) < 18 ? 1 : 2, (cyc - l) >= 19);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_sb(0, 1'b0);
    chk("rst_dat_a", 32'(dat_a), 32'd0);
    chk("rst_ovr", 32'({ovr_a, ovr_b}), 32'd0);
    startup();
    // format conversion: A plain, B negated with saturation
    drv(14'h2000, 14'h2000, 14'h0000, 14'h0000);
    drv(14'h3FFF, 14'h3FFF, 14'h1FFF, 14'h2001);
    drv(14'h0000, 14'h0000, 14'h2000, 14'h1FFF);
    drv(14'h1234, 14'h1234, 14'h3234, 14'h0DCC);
    drv(14'h2ABC, 14'h2ABC, 14'h0ABC, 14'h3544);
    repeat (4) @(negedge clk);
    chk("ovr_both_set", 32'({ovr_a, ovr_b}), 32'b11);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("ovr_both_clr", 32'({ovr_a, ovr_b}), 32'b00);
    // single full-scale A sample
    drv(14'h3FFF, 14'h1000, 14'h1FFF, 14'h1000);
    drv(14'h1000, 14'h1000, 14'h3000, 14'h1000);
    @(negedge clk);
    chk("ovr_a_set", 32'(ovr_a), 32'd1);
    chk("ovr_b_quiet", 32'(ovr_b), 32'd0);
    repeat (2) @(negedge clk);
    chk("ovr_a_sticky", 32'(ovr_a), 32'd1);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("ovr_a_clr", 32'(ovr_a), 32'd0);
    // set and clear on the same edge: set wins
    drv(14'h0000, 14'h1000, 14'h2000, 14'h1000);
    @(negedge clk);
    din_a = 14'h1000;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("ovr_a_set_wins", 32'(ovr_a), 32'd1);
    chk("ovr_b_still0", 32'(ovr_b), 32'd0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("ovr_a_clr2", 32'(ovr_a), 32'd0);
    // one-cycle lock drop, full-scale codes while settling
    @(negedge clk);
    locked = 1'b0;
    check_sb(2, 1'b1);
    for (int i = 1; i < 24; i++) begin
      @(negedge clk);
      if (i == 1) locked = 1'b1;
      if (i == 5) begin din_a = 14'h3FFF; din_b = 14'h0000; end
      if (i == 6) begin din_a = 14'h0000; din_b = 14'h3FFF; end
      if (i == 7) begin din_a = 14'h1000; din_b = 14'h1000; end
      check_sb(i < 3 ? 2 : i == 3 ? 0 : i < 20 ? 1 : 2, i < 4 || i >= 21);
    end
    chk("ovr_settle_quiet", 32'({ovr_a, ovr_b}), 32'b00);
    // async reset between edges while in RUN
    drv(14'h3FFF, 14'h1234, 14'h1FFF, 14'h0DCC);
    drv(14'h1234, 14'h1234, 14'h3234, 14'h0DCC);
    repeat (3) @(negedge clk);
    chk("pre_rst_ovr_a", 32'(ovr_a), 32'd1);
    chk("pre_rst_dat_a", 32'(dat_a), 32'h3234);
    #2 rst_n = 1'b0;
    #1;
    check_sb(0, 1'b0);
    chk("async_dat_a", 32'(dat_a), 32'd0);
    chk("async_dat_b", 32'(dat_b), 32'd0);
    chk("async_ovr", 32'({ovr_a, ovr_b}), 32'd0);
    startup();
    drv(14'h2001, 14'h1FFF, 14'h0001, 14'h0001);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
